ftdi_packet_engine: RTL

- Synchronous packet processor between `ftdiController` and the user logic. Replaces the two-byte edge-triggered echo with a clocked, parametrised command engine.
- Receives framed packets `[CMD][LEN][LEN payload bytes]` over the controller's RX four-phase interlock.
- Buffers the payload, applies a command-selected transform, and returns the result over a TX four-phase interlock.
- Sits in `top` between the `ftdiController` ctrl-side ports and the status LED logic.

---
 rtl/ftdi_packet_engine_if.sv | 23 ++
 rtl/ftdi_packet_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ftdi_packet_engine_if.sv
// RX/TX four-phase interlock bundle between ftdiController and ftdi_packet_engine.
// master = controller side, slave = packet engine side.
interface ftdi_packet_engine_if #(
   parameter int DATA_W = 8
);
   logic              in_rx_prd_rdy;
   logic [DATA_W-1:0] in_rx_data;
   logic              out_rx_cons_rdy;
   logic              out_rx_ena;
   logic              out_tx_data_rdy;
   logic [DATA_W-1:0] out_tx_data;
   logic              in_tx_ack;

   modport master (
      output in_rx_prd_rdy, in_rx_data, in_tx_ack,
      input  out_rx_cons_rdy, out_rx_ena, out_tx_data_rdy, out_tx_data
   );

   modport slave (
      input  in_rx_prd_rdy, in_rx_data, in_tx_ack,
      output out_rx_cons_rdy, out_rx_ena, out_tx_data_rdy, out_tx_data
   );
endinterface

// File: rtl/ftdi_packet_engine.sv
// Framed [CMD][LEN][payload] command engine: buffers payload, transforms it, returns it over TX.
// Define FTDI_PKT_CHECKSUM_EN to append an XOR checksum byte after every response.
module ftdi_packet_engine #(
   parameter int                DATA_W   = 8,
   parameter int                MAX_LEN  = 16,
   parameter logic [DATA_W-1:0] CMD_INV  = 8'hAA,
   parameter logic [DATA_W-1:0] CMD_ECHO = 8'h55,
   parameter logic [DATA_W-1:0] CMD_REV  = 8'hC3,
   parameter logic [DATA_W-1:0] ERR_CODE = 8'hEE
) (
   input  logic                in_clk,
   input  logic                in_rst,
   ftdi_packet_engine_if.slave ctrl,
   output logic                out_busy,
   output logic                out_err,
   output logic [15:0]         out_pkt_cnt
);

   localparam int                IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [DATA_W-1:0] MAX_LEN_B = DATA_W'(MAX_LEN);
   localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
   localparam logic [DATA_W:0]   TX_ONE    = (DATA_W+1)'(1);
`ifdef FTDI_PKT_CHECKSUM_EN
   localparam logic [DATA_W:0]   N_EXTRA   = (DATA_W+1)'(1);
`else
   localparam logic [DATA_W:0]   N_EXTRA   = '0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_RESP, S_DONE} state_t;
   typedef enum logic [1:0] {PH_PREP, PH_ARM, PH_ACK, PH_REL} phase_t;

   state_t            state, state_nxt;
   phase_t            phase, phase_nxt;

   logic              rx_cons_rdy;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] cmd_q;
   logic [DATA_W-1:0] len_q;
   logic [DATA_W-1:0] pay_cnt;
   logic [DATA_W-1:0] resp_cnt;
   logic              err_resp;
   logic [DATA_W:0]   tx_idx;
   logic [DATA_W:0]   n_tx;
   logic              tx_rdy;
   logic [DATA_W-1:0] tx_data;
   logic [DATA_W-1:0] pay_mem [MAX_LEN];
   logic [IDX_W-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_byte;
   logic [DATA_W-1:0] resp_byte;

   logic rx_active, rx_capture, rx_consume;
   logic cmd_known, len_bad, pay_last;
   logic tx_load, tx_fire, tx_taken;

   assign rx_active  = (state == S_IDLE) || (state == S_LEN) || (state == S_PAYLOAD);
   assign rx_capture = rx_active && ctrl.in_rx_prd_rdy && !rx_cons_rdy;
   assign rx_consume = rx_active && !ctrl.in_rx_prd_rdy && rx_cons_rdy;
   assign cmd_known  = (cmd_q == CMD_INV) || (cmd_q == CMD_ECHO) || (cmd_q == CMD_REV);
   assign len_bad    = (rx_q > MAX_LEN_B);
   assign pay_last   = ((pay_cnt + ONE) == len_q);
   assign n_tx       = {1'b0, resp_cnt} + N_EXTRA;

   assign tx_load  = (state == S_RESP) && (phase == PH_PREP) && (tx_idx != n_tx);
   assign tx_fire  = (state == S_RESP) && (phase == PH_ARM) && !ctrl.in_tx_ack;
   assign tx_taken = (state == S_RESP) && (phase == PH_ACK) && ctrl.in_tx_ack;

   // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state <= S_IDLE;
         phase <= PH_PREP;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
      end
   end

   // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      case (state)
         S_IDLE:    if (rx_consume) state_nxt = S_LEN;
         S_LEN:     if (rx_consume) state_nxt = (len_bad || rx_q == '0) ? S_RESP : S_PAYLOAD;
         S_PAYLOAD: if (rx_consume && pay_last) state_nxt = S_RESP;
         S_RESP: begin
            // PREP adds a cycle so TX request never follows the last RX ack too closely
            unique case (phase)
               PH_PREP: if (tx_idx == n_tx) state_nxt = S_DONE;
                        else                phase_nxt = PH_ARM;
               PH_ARM:  if (!ctrl.in_tx_ack) phase_nxt = PH_ACK;
               PH_ACK:  if (ctrl.in_tx_ack)  phase_nxt = PH_REL;
               PH_REL:  if (!ctrl.in_tx_ack) phase_nxt = PH_PREP;
            endcase
         end
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      if (state_nxt != S_RESP) phase_nxt = PH_PREP;
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         rx_cons_rdy <= 1'b0;
         rx_q        <= '0;
         cmd_q       <= '0;
         len_q       <= '0;
         pay_cnt     <= '0;
         resp_cnt    <= '0;
         err_resp    <= 1'b0;
         tx_idx      <= '0;
         tx_rdy      <= 1'b0;
         tx_data     <= '0;
         out_err     <= 1'b0;
         out_pkt_cnt <= '0;
      end else begin
         out_err <= 1'b0;
         if (rx_capture) begin
            rx_cons_rdy <= 1'b1;
            rx_q        <= ctrl.in_rx_data;
         end else if (rx_consume) begin
            rx_cons_rdy <= 1'b0;
         end

         if (rx_consume) begin
            case (state)
               S_IDLE: cmd_q <= rx_q;
               S_LEN: begin
                  len_q   <= rx_q;
                  pay_cnt <= '0;
                  if (len_bad) begin
                     err_resp <= 1'b1;
                     resp_cnt <= ONE;
                     out_err  <= 1'b1;
                  end else if (rx_q == '0) begin
                     err_resp <= 1'b0;
                     resp_cnt <= '0;
                  end else begin
                     err_resp <= !cmd_known;
                     resp_cnt <= cmd_known ? rx_q : ONE;
                  end
               end
               S_PAYLOAD: begin
                  pay_cnt <= pay_cnt + ONE;
                  if (pay_last && !cmd_known) out_err <= 1'b1;
               end
               default: ;
            endcase
         end

         if (state != S_RESP) tx_idx <= '0;
         if (tx_load) tx_data <= resp_byte;
         if (tx_fire) tx_rdy <= 1'b1;
         if (tx_taken) begin
            tx_rdy <= 1'b0;
            tx_idx <= tx_idx + TX_ONE;
         end

         if (state == S_DONE) out_pkt_cnt <= out_pkt_cnt + 16'd1;
      end
   end

   // NOTE: the payload buffer has no reset; every location read was written earlier in the same packet.
   always_ff @(posedge in_clk) begin
      if (rx_consume && state == S_PAYLOAD && cmd_known)
         pay_mem[IDX_W'(pay_cnt)] <= rx_q;
   end

`ifdef FTDI_PKT_CHECKSUM_EN
   logic [DATA_W-1:0] chk_q;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst)                chk_q <= '0;
      else if (state != S_RESP)  chk_q <= '0;
      else if (tx_taken)         chk_q <= chk_q ^ tx_data;
   end
`endif

   always_comb begin
      rd_addr = (cmd_q == CMD_REV) ? IDX_W'(len_q - ONE - tx_idx[DATA_W-1:0])
                                   : IDX_W'(tx_idx);
      rd_byte = pay_mem[rd_addr];
      if (err_resp)               resp_byte = ERR_CODE;
      else if (cmd_q == CMD_INV)  resp_byte = ~rd_byte;
      else                        resp_byte = rd_byte;
`ifdef FTDI_PKT_CHECKSUM_EN
      if (tx_idx == {1'b0, resp_cnt}) resp_byte = chk_q;
`endif
   end

   assign ctrl.out_rx_cons_rdy = rx_cons_rdy;
   assign ctrl.out_rx_ena      = (state != S_RESP);
   assign ctrl.out_tx_data_rdy = tx_rdy;
   assign ctrl.out_tx_data     = tx_data;
   assign out_busy             = (state != S_IDLE);

endmodule
